// File: rtl/scan_ctrl.sv
// ---------------------------------------------------------------------------
// scan_ctrl -- multiplexed 7-segment display scanner
//
// Walks through up to DIGITS display positions. The position advances once
// per prescaler period of DIV enabled cycles. Masked positions are skipped
// and blanked. Hex data is taken from a display snapshot. That snapshot is
// refreshed from a holding register only at the frame wrap, so a frame
// never mixes old and new data.
//
// Parameters
//   DIGITS : number of multiplexed digits (2..16)
//   DIV    : enabled CLK cycles per digit dwell (>= 2)
//
// Ports
//   CLK   in   clock, all state changes on rising edge
//   RST   in   synchronous active-high reset
//   EN    in   scan enable; low freezes prescaler and scan state
//   DIR   in   0 = ascending index, 1 = descending index
//   MASK  in   [DIGITS]   per-digit enable (0 = skipped and blanked)
//   DATA  in   [4*DIGITS] hex nibbles, digit i = DATA[4i+3:4i]
//   LOAD  in   request to refresh the snapshot from DATA at next frame
//   DIG   out  [DIGITS]   registered active-low one-hot digit drive
//   SEL   out  [clog2(DIGITS)] registered current digit index
//   SEG   out  [7]        registered active-low segments, gfedcba
//   FRAME out  one-cycle pulse when the scan wraps around
// ---------------------------------------------------------------------------
module scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV    = 1000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      DIR,
    input  logic [DIGITS-1:0]         MASK,
    input  logic [4*DIGITS-1:0]       DATA,
    input  logic                      LOAD,
    output logic [DIGITS-1:0]         DIG,
    output logic [$clog2(DIGITS)-1:0] SEL,
    output logic [6:0]                SEG,
    output logic                      FRAME
);

    localparam int SW = $clog2(DIGITS);
    localparam int PW = $clog2(DIV);

    // ST_WAIT: no digit has been selected yet since reset (first-tick flag).
    // ST_SCAN: normal stepping from the current SEL.
    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [PW-1:0]         prescale_reg, prescale_next;
    logic [SW-1:0]         sel_reg, sel_next;
    logic [DIGITS-1:0]     dig_reg, dig_next;
    logic [6:0]            seg_reg, seg_next;
    logic                  frame_reg, frame_next;
    logic [4*DIGITS-1:0]   snap_reg, snap_next;
    logic [4*DIGITS-1:0]   hold_reg, hold_next;
    logic                  pending_reg, pending_next;

    logic                  tick;
    logic                  mask_any;
    logic [SW-1:0]         lo_idx;
    logic [SW-1:0]         hi_idx;
    logic [SW-1:0]         step_idx;
    logic [3:0]            snap_nib [DIGITS];

    // Hex to active-low gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Index k positions away from cur in the scan direction, modulo DIGITS.
    function automatic logic [SW-1:0] offset_idx(input logic [SW-1:0] cur,
                                                 input int k,
                                                 input logic dn);
        int v;
        if (dn) begin
            v = (int'(cur) + DIGITS - k) % DIGITS;
        end else begin
            v = (int'(cur) + k) % DIGITS;
        end
        return SW'(v);
    endfunction

    // The segment lookup uses the snapshot value that will be current after
    // this edge. Then the first digit of a new frame already shows new data.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign snap_nib[gi] = snap_next[4*gi +: 4];
    end

    assign mask_any = |MASK;
    assign tick     = EN && (prescale_reg == PW'(DIV - 1));

    // Prescaler
    always_comb begin
        prescale_next = prescale_reg;
        if (EN) begin
            prescale_next = tick ? '0 : prescale_reg + 1'b1;
        end
    end

    // Candidate indices: lowest and highest enabled digits for the first
    // tick, and the nearest enabled digit in the scan direction for later
    // ticks. The offset loop runs from farthest to nearest, so the last hit
    // is the nearest. Offset DIGITS maps back to sel_reg itself. That makes
    // a single enabled digit select itself, which is treated as a wrap.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        step_idx = sel_reg;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (MASK[SW'(i)]) begin
                lo_idx = SW'(i);
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (MASK[SW'(i)]) begin
                hi_idx = SW'(i);
            end
        end
        for (int k = DIGITS; k >= 1; k--) begin
            if (MASK[offset_idx(sel_reg, k, DIR)]) begin
                step_idx = offset_idx(sel_reg, k, DIR);
            end
        end
    end

    // Scan FSM, frame detection, snapshot handling and output decode
    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        frame_next   = 1'b0;
        snap_next    = snap_reg;
        hold_next    = hold_reg;
        pending_next = pending_reg;
        dig_next     = '1;
        seg_next     = 7'h7F;

        // With every digit masked, nothing moves and no frame is produced.
        if (tick && mask_any) begin
            case (state_reg)
                ST_WAIT: begin
                    sel_next   = DIR ? hi_idx : lo_idx;
                    state_next = ST_SCAN;
                end
                default: begin
                    sel_next   = step_idx;
                    frame_next = DIR ? (step_idx >= sel_reg)
                                     : (step_idx <= sel_reg);
                end
            endcase
        end

        // The transfer uses the holding value from before this cycle. A LOAD
        // that lands on the wrap cycle therefore waits for the next frame.
        if (frame_next && pending_reg) begin
            snap_next    = hold_reg;
            pending_next = 1'b0;
        end
        if (EN && LOAD) begin
            hold_next    = DATA;
            pending_next = 1'b1;
        end

        // Blanking follows MASK every cycle, even while EN is low.
        if (state_next == ST_SCAN && MASK[sel_next]) begin
            dig_next[sel_next] = 1'b0;
            seg_next           = hex7(snap_nib[sel_next]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_WAIT;
            prescale_reg <= '0;
            sel_reg      <= '0;
            dig_reg      <= '1;
            seg_reg      <= 7'h7F;
            frame_reg    <= 1'b0;
            snap_reg     <= '0;
            hold_reg     <= '0;
            pending_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prescale_reg <= prescale_next;
            sel_reg      <= sel_next;
            dig_reg      <= dig_next;
            seg_reg      <= seg_next;
            frame_reg    <= frame_next;
            snap_reg     <= snap_next;
            hold_reg     <= hold_next;
            pending_reg  <= pending_next;
        end
    end

    assign DIG   = dig_reg;
    assign SEL   = sel_reg;
    assign SEG   = seg_reg;
    assign FRAME = frame_reg;

endmodule

// File: tb/tb_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_ctrl -- self-checking bench for scan_ctrl (DIGITS=8, DIV=4)
//
// A behavioural model predicts DIG/SEL/SEG/FRAME after every edge. The
// model works from the list of enabled digits and from plain counters.
// Directed phases cover the documented scenarios. A random phase follows.
// ---------------------------------------------------------------------------
module tb_scan_ctrl;

    localparam int DIGITS = 8;
    localparam int DIV    = 4;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        DIR;
    logic [7:0]  MASK;
    logic [31:0] DATA;
    logic        LOAD;
    logic [7:0]  DIG;
    logic [2:0]  SEL;
    logic [6:0]  SEG;
    logic        FRAME;

    int tests_run    = 0;
    int tests_failed = 0;

    scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .DIR   (DIR),
        .MASK  (MASK),
        .DATA  (DATA),
        .LOAD  (LOAD),
        .DIG   (DIG),
        .SEL   (SEL),
        .SEG   (SEG),
        .FRAME (FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int          m_cnt;
    int          m_sel;
    bit          m_started;
    logic [31:0] m_snap;
    logic [31:0] m_hold;
    bit          m_pend;
    logic [7:0]  m_dig;
    logic [6:0]  m_seg;
    bit          m_frame;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    task automatic model_edge();
        bit tick;
        int en_list[$];
        int nxt;
        if (RST) begin
            m_cnt = 0; m_sel = 0; m_started = 0;
            m_snap = '0; m_hold = '0; m_pend = 0;
            m_dig = 8'hFF; m_seg = 7'h7F; m_frame = 0;
            return;
        end
        tick    = 0;
        m_frame = 0;
        if (EN) begin
            tick  = (m_cnt == DIV - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        for (int i = 0; i < DIGITS; i++) if (MASK[i]) en_list.push_back(i);
        if (tick && en_list.size() > 0) begin
            if (!m_started) begin
                m_sel     = DIR ? en_list[en_list.size()-1] : en_list[0];
                m_started = 1;
            end else begin
                nxt = -1;
                if (!DIR) begin
                    foreach (en_list[i]) if (nxt < 0 && en_list[i] > m_sel) nxt = en_list[i];
                    if (nxt < 0) begin nxt = en_list[0]; m_frame = 1; end
                end else begin
                    for (int i = en_list.size() - 1; i >= 0; i--)
                        if (nxt < 0 && en_list[i] < m_sel) nxt = en_list[i];
                    if (nxt < 0) begin nxt = en_list[en_list.size()-1]; m_frame = 1; end
                end
                m_sel = nxt;
            end
        end
        if (m_frame && m_pend) begin m_snap = m_hold; m_pend = 0; end
        if (EN && LOAD) begin m_hold = DATA; m_pend = 1; end
        if (m_started && MASK[m_sel]) begin
            m_dig = ~(8'd1 << m_sel);
            m_seg = seg_of(m_snap[4*m_sel +: 4]);
        end else begin
            m_dig = 8'hFF;
            m_seg = 7'h7F;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check("DIG",   32'(DIG),   32'(m_dig));
        check("SEL",   32'(SEL),   32'(m_sel));
        check("SEG",   32'(SEG),   32'(m_seg));
        check("FRAME", 32'(FRAME), 32'(m_frame));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        run(2);
        RST = 1'b0;
    endtask

    // Step until SEL shows the target; an exhausted budget is a failure.
    task automatic wait_sel(input int target, input int budget);
        for (int i = 0; i < budget && int'(SEL) != target; i++) step();
        check("wait_sel", 32'(SEL), 32'(target));
    endtask

    int frames;

    initial begin
        RST = 1'b1; EN = 1'b0; DIR = 1'b0; MASK = 8'hFF; DATA = '0; LOAD = 1'b0;
        #1;
        do_reset();
        check("rst_dig", 32'(DIG), 32'hFF);
        check("rst_seg", 32'(SEG), 32'h7F);

        // Full mask ascending: first tick on the 4th enabled edge.
        EN = 1'b1;
        run(3);
        check("pre_tick_dig", 32'(DIG), 32'hFF);
        run(1);
        check("first_dig", 32'(DIG), 32'hFE);
        check("first_sel", 32'(SEL), 32'd0);
        check("first_seg", 32'(SEG), 32'h40);
        frames = 0;
        for (int i = 0; i < 32; i++) begin step(); if (FRAME) frames++; end
        check("asc_frames", 32'(frames), 32'd1);
        check("asc_wrap_sel", 32'(SEL), 32'd0);

        // Sparse mask 0x25: 0,2,5,0,...
        MASK = 8'h25;
        run(40);

        // Descending from reset, then a direction flip at SEL=3.
        MASK = 8'hFF; DIR = 1'b1;
        do_reset();
        run(4);
        check("desc_first_sel", 32'(SEL), 32'd7);
        check("desc_first_dig", 32'(DIG), 32'h7F);
        wait_sel(3, 40);
        DIR = 1'b0;
        run(4);
        check("flip_sel", 32'(SEL), 32'd4);

        // Snapshot loads: later LOAD before the frame wins.
        wait_sel(3, 64);
        DATA = 32'h0000_0008; LOAD = 1'b1; step(); LOAD = 1'b0;
        wait_sel(0, 64);
        check("load_seg8", 32'(SEG), 32'h00);
        wait_sel(3, 64);
        DATA = 32'h0000_0008; LOAD = 1'b1; step(); LOAD = 1'b0;
        run(2);
        DATA = 32'h0000_0001; LOAD = 1'b1; step(); LOAD = 1'b0;
        wait_sel(0, 64);
        check("load_seg1", 32'(SEG), 32'h79);

        // All masked, then mid-dwell blanking of the current digit.
        MASK = 8'h00;
        frames = 0;
        for (int i = 0; i < 16; i++) begin step(); if (FRAME) frames++; end
        check("nomask_frames", 32'(frames), 32'd0);
        check("nomask_dig", 32'(DIG), 32'hFF);
        MASK = 8'hFF;
        wait_sel(2, 64);
        step();
        MASK = 8'hFB;
        step();
        check("blank_dig", 32'(DIG), 32'hFF);
        check("blank_seg", 32'(SEG), 32'h7F);
        MASK = 8'hFF;

        // Reset mid-frame with a pending load.
        wait_sel(5, 64);
        DATA = 32'hFFFF_FFFF; LOAD = 1'b1; step(); LOAD = 1'b0;
        RST = 1'b1; step(); RST = 1'b0;
        check("rst2_sel", 32'(SEL), 32'd0);
        check("rst2_dig", 32'(DIG), 32'hFF);
        run(3);
        check("rst2_pre_dig", 32'(DIG), 32'hFF);
        run(1);
        check("rst2_tick_dig", 32'(DIG), 32'hFE);
        run(40);

        // Randomised operation checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            EN   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 40) == 0) DIR = ~DIR;
            if ($urandom_range(0, 60) == 0)
                MASK = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            LOAD = ($urandom_range(0, 15) == 0);
            DATA = $urandom;
            RST  = ($urandom_range(0, 300) == 0);
            step();
        end
        RST = 1'b0; LOAD = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
